mtimer: RTL and testbench
=========================

# mtimer

Memory-mapped RISC-V machine timer: the interrupt source at the other end of the CSR unit's `interrupt` input. It keeps a 64-bit `mtime` counter advanced by a programmable prescaler and compares it against a 64-bit `mtimecmp`. When the compare is met it drives a one-cycle pulse onto the core's `interrupt` line, plus a level copy for status. It sits on the data-memory bus beside the LSU.

## Interface
- `PRESCALE_W`, default 8: width of the prescale field and counter.
- `clk` in 1: core clock.
- `rst` in 1: reset; synchronous, active-low (`rst`=0 resets on the `clk` edge).
- `bus_req` in 1: access request, sampled each `clk` edge.
- `bus_we` in 1: 1 = write, 0 = read; qualified by `bus_req`.
- `bus_addr` in 5: byte offset; `[4:2]` selects the word and `[1:0]` is ignored.
- `bus_wdata` in 32: write data.
- `bus_rdata` out 32: read data; valid only while `bus_ack`=1, otherwise 0.
- `bus_ack` out 1: one-cycle acknowledge.
- `irq_level` out 1: registered `mtime >= mtimecmp`.
- `irq_pulse` out 1: one-cycle rising edge of `irq_level`; connects to the CSR `interrupt` input.

## Operation
- Register map (word offsets):
  - 0x00 MTIME_LO.
  - 0x04 MTIME_HI.
  - 0x08 MTIMECMP_LO.
  - 0x0C MTIMECMP_HI.
  - 0x10 CTRL: bit0 EN, bits[8+PRESCALE_W-1:8] PRESCALE, other bits read 0.
  - 0x14–0x1C: unmapped; reads return 0, writes are ignored, and the access is still acked.
- Reset values: mtime=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, CTRL=0, prescale counter=0, HI shadow invalid, and all outputs 0.
- Prescaler: while EN=1 the counter increments every cycle. When it equals PRESCALE it wraps to 0 and issues a tick. A tick therefore occurs every PRESCALE+1 cycles. EN=0 holds the counter at its current value (it is not cleared).
- On a tick, mtime increments by 1 (unsigned, 64-bit). 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
- Write vs tick in the same cycle:
  - Write to MTIME_LO: LO takes `bus_wdata`, and no carry goes to HI.
  - Write to MTIME_HI: HI takes `bus_wdata`; LO increments normally and any carry is dropped.
  - The bus write always wins over the tick.
- A write to CTRL that changes PRESCALE resets the prescale counter to 0.
- Atomic read:
  - A read of MTIME_LO snapshots the live MTIME_HI (its pre-tick value in that cycle) into a shadow and sets shadow-valid.
  - A read of MTIME_HI returns the shadow and clears shadow-valid if it was set; otherwise it returns the live HI.
  - Any write to MTIME_HI or MTIME_LO clears shadow-valid.
- Compare: `irq_level` is registered each cycle from the unsigned 64-bit `mtime >= mtimecmp` on current register values. Software clears it by raising mtimecmp or lowering mtime.
- `irq_pulse`: `irq_level` & ~`irq_level_q`, registered, giving exactly one cycle per rising edge. A level that stays high does not re-pulse.

## Timing
- Bus:
  - A request accepted at edge N produces `bus_ack`=1 during cycle N+1, with `bus_rdata` valid for a read.
  - Back-to-back requests are allowed, one per cycle, each acked in the following cycle. No wait states.
- Write visibility: register contents update at edge N, and a read accepted at edge N+1 sees the new value.
- Interrupt latency: if mtime reaches mtimecmp at edge T (tick or write), then `irq_level`=1 from edge T+1 and `irq_pulse`=1 for the cycle T+1..T+2 only.
- Reset mid-operation: `rst`=0 at any edge returns every register and output to reset values on that edge. An in-flight ack is dropped.

## Structure
- Package `mtimer_pkg` holds:
  - the address-offset enum `type_mtimer_addr` (MTIME_LO_ADDR … CTRL_ADDR);
  - CTRL bit positions (CTRL_EN_BIT=0, CTRL_PRESCALE_LSB=8);
  - the reset constant MTIMECMP_RST=64'hFFFF_FFFF_FFFF_FFFF.
- Sub-module `mtimer_prescaler` (clk, rst, en, prescale, clr → tick) contains the prescale counter and tick generation.
- The top level contains the bus decode, the 64-bit registers and shadow, the compare, and the irq edge logic.

## Test plan
- Reset, then read CMP_LO, CMP_HI, CTRL and MTIME_LO back-to-back → rdata 0xFFFF_FFFF, 0xFFFF_FFFF, 0, 0. Each ack comes exactly one cycle after its req, and `irq_level`=`irq_pulse`=0.
- CMP_HI=0, CMP_LO=10, CTRL=0x1 (PRESCALE 0) → `irq_pulse` high for exactly 1 cycle, 1 cycle after mtime reaches 10. `irq_level` stays 1; writing CMP_LO=0x100 clears `irq_level` 1 cycle after the write edge, with no further pulse.
- CTRL=0x0301 (PRESCALE 3), run 40 cycles from enable → MTIME_LO reads 10 (±1 for the read edge). With EN=0, MTIME_LO holds for 20 cycles.
- Wrap and atomic read: MTIME_LO=0xFFFF_FFFE, MTIME_HI=0, PRESCALE 0; read LO on the edge where LO goes 0xFFFF_FFFF→0 → the LO read returns 0xFFFF_FFFF and the next HI read returns 0 (shadow). A subsequent live HI read returns 1.
- Write MTIME_LO=0x55 on a tick edge where LO=0xFFFF_FFFF → LO=0x55 and HI is unchanged (no carry).
- Mid-count, drive `rst`=0 for one edge with `irq_level`=1 and a read pending → next cycle all registers are at reset values, `bus_ack`=0, and `irq_level`=0.

Source files
------------

// File: rtl/mtimer_pkg.sv
// Shared definitions for the machine timer: register word offsets,
// CTRL field positions and reset constants.
package mtimer_pkg;

    // Word offsets selected by bus_addr[4:2]; offsets 5..7 are unmapped.
    typedef enum logic [2:0] {
        MTIME_LO_ADDR    = 3'd0,
        MTIME_HI_ADDR    = 3'd1,
        MTIMECMP_LO_ADDR = 3'd2,
        MTIMECMP_HI_ADDR = 3'd3,
        CTRL_ADDR        = 3'd4
    } type_mtimer_addr;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_PRESCALE_LSB = 8;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/mtimer_prescaler.sv
// Prescale counter: counts 0..prescale while enabled and flags a tick on
// the cycle the count sits at prescale, so one tick every prescale+1 cycles.
module mtimer_prescaler import mtimer_pkg::*; #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  clr,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] count_r;
    logic [PRESCALE_W-1:0] count_next_s;

    // Next count: clear wins, otherwise advance/wrap while enabled, hold when disabled.
    always_comb begin
        count_next_s = count_r;
        if (clr) begin
            count_next_s = {PRESCALE_W{1'b0}};
        end else if (en) begin
            if (count_r == prescale) begin
                count_next_s = {PRESCALE_W{1'b0}};
            end else begin
                count_next_s = count_r + PRESCALE_W'(1);
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= {PRESCALE_W{1'b0}};
        end else begin
            count_r <= count_next_s;
        end
    end

    // Tick is a pure decode of registered state, so it cannot form a loop with clr.
    assign tick = en && (count_r == prescale);

endmodule

// File: rtl/mtimer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp on a single-cycle bus, with an
// atomic HI shadow for split reads and a registered level/pulse interrupt.
module mtimer import mtimer_pkg::*; #(
    parameter int PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [4:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ack,
    output logic        irq_level,
    output logic        irq_pulse
);

    logic [63:0]           mtime_r;
    logic [63:0]           mtime_next_s;
    logic [63:0]           mtime_inc_s;
    logic [63:0]           mtimecmp_r;
    logic [63:0]           mtimecmp_next_s;
    logic                  ctrl_en_r;
    logic                  ctrl_en_next_s;
    logic [PRESCALE_W-1:0] ctrl_prescale_r;
    logic [PRESCALE_W-1:0] ctrl_prescale_next_s;
    logic [PRESCALE_W-1:0] wr_prescale_s;
    logic [31:0]           ctrl_word_s;
    logic [31:0]           shadow_r;
    logic [31:0]           shadow_next_s;
    logic                  shadow_valid_r;
    logic                  shadow_valid_next_s;
    logic [31:0]           rdata_r;
    logic [31:0]           rdata_next_s;
    logic                  ack_r;
    logic                  irq_level_r;
    logic                  irq_pulse_r;
    logic                  tick_s;
    logic                  clr_s;
    logic                  rd_s;
    logic                  wr_s;
    logic                  cmp_hit_s;
    logic                  unused_s;
    type_mtimer_addr       addr_s;

    assign addr_s        = type_mtimer_addr'(bus_addr[4:2]);
    assign rd_s          = bus_req & ~bus_we;
    assign wr_s          = bus_req & bus_we;
    assign unused_s      = ^bus_addr[1:0];
    assign wr_prescale_s = bus_wdata[CTRL_PRESCALE_LSB +: PRESCALE_W];
    assign mtime_inc_s   = mtime_r + 64'd1;
    assign cmp_hit_s     = (mtime_r >= mtimecmp_r);

    // Changing PRESCALE restarts the count so the new period starts cleanly.
    assign clr_s = wr_s && (addr_s == CTRL_ADDR) && (wr_prescale_s != ctrl_prescale_r);

    mtimer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (ctrl_en_r),
        .prescale (ctrl_prescale_r),
        .clr      (clr_s),
        .tick     (tick_s)
    );

    // CTRL read-back word: EN and PRESCALE in place, everything else zero.
    always_comb begin
        ctrl_word_s = 32'd0;
        ctrl_word_s[CTRL_EN_BIT] = ctrl_en_r;
        ctrl_word_s[CTRL_PRESCALE_LSB +: PRESCALE_W] = ctrl_prescale_r;
    end

    // Bus decode: next register values and read data; a write beats the tick.
    always_comb begin
        mtime_next_s         = tick_s ? mtime_inc_s : mtime_r;
        mtimecmp_next_s      = mtimecmp_r;
        ctrl_en_next_s       = ctrl_en_r;
        ctrl_prescale_next_s = ctrl_prescale_r;
        shadow_next_s        = shadow_r;
        shadow_valid_next_s  = shadow_valid_r;
        rdata_next_s         = 32'd0;
        if (wr_s) begin
            case (addr_s)
                MTIME_LO_ADDR: begin
                    // HI keeps its value: a LO write swallows any carry.
                    mtime_next_s        = {mtime_r[63:32], bus_wdata};
                    shadow_valid_next_s = 1'b0;
                end
                MTIME_HI_ADDR: begin
                    // LO still ticks, but its carry is lost under the HI write.
                    mtime_next_s        = {bus_wdata, (tick_s ? mtime_inc_s[31:0] : mtime_r[31:0])};
                    shadow_valid_next_s = 1'b0;
                end
                MTIMECMP_LO_ADDR: begin
                    mtimecmp_next_s[31:0] = bus_wdata;
                end
                MTIMECMP_HI_ADDR: begin
                    mtimecmp_next_s[63:32] = bus_wdata;
                end
                CTRL_ADDR: begin
                    ctrl_en_next_s       = bus_wdata[CTRL_EN_BIT];
                    ctrl_prescale_next_s = wr_prescale_s;
                end
                default: begin
                    mtimecmp_next_s = mtimecmp_r;
                end
            endcase
        end else if (rd_s) begin
            case (addr_s)
                MTIME_LO_ADDR: begin
                    // Capture the pre-tick HI so a following HI read pairs with this LO.
                    rdata_next_s        = mtime_r[31:0];
                    shadow_next_s       = mtime_r[63:32];
                    shadow_valid_next_s = 1'b1;
                end
                MTIME_HI_ADDR: begin
                    rdata_next_s        = shadow_valid_r ? shadow_r : mtime_r[63:32];
                    shadow_valid_next_s = 1'b0;
                end
                MTIMECMP_LO_ADDR: begin
                    rdata_next_s = mtimecmp_r[31:0];
                end
                MTIMECMP_HI_ADDR: begin
                    rdata_next_s = mtimecmp_r[63:32];
                end
                CTRL_ADDR: begin
                    rdata_next_s = ctrl_word_s;
                end
                default: begin
                    rdata_next_s = 32'd0;
                end
            endcase
        end else begin
            rdata_next_s = 32'd0;
        end
    end

    // Timer, compare, control and shadow registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mtime_r         <= 64'd0;
            mtimecmp_r      <= MTIMECMP_RST;
            ctrl_en_r       <= 1'b0;
            ctrl_prescale_r <= {PRESCALE_W{1'b0}};
            shadow_r        <= 32'd0;
            shadow_valid_r  <= 1'b0;
        end else begin
            mtime_r         <= mtime_next_s;
            mtimecmp_r      <= mtimecmp_next_s;
            ctrl_en_r       <= ctrl_en_next_s;
            ctrl_prescale_r <= ctrl_prescale_next_s;
            shadow_r        <= shadow_next_s;
            shadow_valid_r  <= shadow_valid_next_s;
        end
    end

    // Registered bus response and interrupt level/edge outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ack_r       <= 1'b0;
            rdata_r     <= 32'd0;
            irq_level_r <= 1'b0;
            irq_pulse_r <= 1'b0;
        end else begin
            ack_r       <= bus_req;
            rdata_r     <= rdata_next_s;
            irq_level_r <= cmp_hit_s;
            irq_pulse_r <= cmp_hit_s & ~irq_level_r;
        end
    end

    assign bus_ack   = ack_r;
    assign bus_rdata = rdata_r;
    assign irq_level = irq_level_r;
    assign irq_pulse = irq_pulse_r;

endmodule

// File: tb/tb_mtimer.sv
// Bench for mtimer: reset/read-back vector table, hand-written interrupt,
// prescaler, wrap/shadow and reset sequences, then random traffic against
// a 64-bit arithmetic reference model.
module tb_mtimer;

    localparam int PW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_req;
    logic        bus_we;
    logic [4:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        irq_level;
    logic        irq_pulse;

    mtimer #(.PRESCALE_W(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .irq_level (irq_level),
        .irq_pulse (irq_pulse)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    logic [63:0]   m_mtime;
    logic [63:0]   m_cmp;
    logic          m_en;
    logic [PW-1:0] m_pre;
    logic [PW-1:0] m_pcnt;
    logic [31:0]   m_sh;
    logic          m_shv;
    logic          e_ack;
    logic [31:0]   e_rdata;
    logic          e_level;
    logic          e_pulse;

    typedef struct {
        logic        req;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        ack;
        logic [31:0] rdata;
        logic        level;
        logic        pulse;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_mtime = 64'd0;
        m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
        m_en    = 1'b0;
        m_pre   = '0;
        m_pcnt  = '0;
        m_sh    = 32'd0;
        m_shv   = 1'b0;
        e_ack   = 1'b0;
        e_rdata = 32'd0;
        e_level = 1'b0;
        e_pulse = 1'b0;
    endtask

    // One clock edge of the timer, expressed with plain 64-bit arithmetic.
    task automatic model_edge(input logic r, input logic req, input logic we,
                              input logic [4:0] addr, input logic [31:0] wd);
        logic          tk;
        logic          hit;
        logic [63:0]   nxt;
        logic [PW-1:0] np;
        if (!r) begin
            model_reset();
        end else begin
            tk      = m_en && (m_pcnt == m_pre);
            hit     = (m_mtime >= m_cmp);
            e_pulse = hit && !e_level;
            e_level = hit;
            e_ack   = req;
            e_rdata = 32'd0;
            nxt     = tk ? m_mtime + 64'd1 : m_mtime;
            if (req && !we) begin
                case (addr[4:2])
                    3'd0: begin e_rdata = m_mtime[31:0]; m_sh = m_mtime[63:32]; m_shv = 1'b1; end
                    3'd1: begin e_rdata = m_shv ? m_sh : m_mtime[63:32]; m_shv = 1'b0; end
                    3'd2: e_rdata = m_cmp[31:0];
                    3'd3: e_rdata = m_cmp[63:32];
                    3'd4: e_rdata = {16'd0, m_pre, 7'd0, m_en};
                    default: e_rdata = 32'd0;
                endcase
            end
            if (m_en) m_pcnt = (m_pcnt == m_pre) ? '0 : m_pcnt + 1'b1;
            if (req && we) begin
                case (addr[4:2])
                    3'd0: begin nxt = {m_mtime[63:32], wd}; m_shv = 1'b0; end
                    3'd1: begin nxt[63:32] = wd; m_shv = 1'b0; end
                    3'd2: m_cmp[31:0] = wd;
                    3'd3: m_cmp[63:32] = wd;
                    3'd4: begin
                        np = wd[15:8];
                        if (np != m_pre) m_pcnt = '0;
                        m_pre = np;
                        m_en  = wd[0];
                    end
                    default: ;
                endcase
            end
            m_mtime = nxt;
        end
    endtask

    task automatic step(input logic r, input logic req, input logic we,
                        input logic [4:0] addr, input logic [31:0] wd);
        rst       = r;
        bus_req   = req;
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = wd;
        @(posedge clk);
        model_edge(r, req, we, addr, wd);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d); step(1'b1, 1'b1, 1'b1, a, d); endtask
    task automatic rd(input logic [4:0] a); step(1'b1, 1'b1, 1'b0, a, 32'd0); endtask
    task automatic idle(); step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0); endtask
    task automatic do_reset(); step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0); endtask

    task automatic check_model(input string tag);
        check({tag, "_ack"},   bus_ack,   e_ack);
        check({tag, "_rdata"}, bus_rdata, e_rdata);
        check({tag, "_level"}, irq_level, e_level);
        check({tag, "_pulse"}, irq_pulse, e_pulse);
    endtask

    int          first_lvl;
    int          pulses;
    int          pulse_at;
    logic        r_rst;
    logic        r_req;
    logic        r_we;
    logic [4:0]  r_addr;
    logic [31:0] r_wd;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset();
        do_reset();
        check("rst_ack",   bus_ack,   1'b0);
        check("rst_rdata", bus_rdata, 32'd0);
        check("rst_level", irq_level, 1'b0);
        check("rst_pulse", irq_pulse, 1'b0);

        // Reset read-back and unmapped-offset table
        tbl[0] = '{1'b1, 1'b0, 5'h08, 32'h0,    1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 5'h0C, 32'h0,    1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 5'h10, 32'h0,    1'b1, 32'h0,         1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 5'h00, 32'h0,    1'b1, 32'h0,         1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 5'h00, 32'h0,    1'b0, 32'h0,         1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 5'h17, 32'h0,    1'b1, 32'h0,         1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 5'h18, 32'hDEAD, 1'b1, 32'h0,         1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 5'h07, 32'h0,    1'b1, 32'h0,         1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            step(1'b1, tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata);
            check($sformatf("vec%0d_ack", i),   bus_ack,   tbl[i].ack);
            check($sformatf("vec%0d_rdata", i), bus_rdata, tbl[i].rdata);
            check($sformatf("vec%0d_level", i), irq_level, tbl[i].level);
            check($sformatf("vec%0d_pulse", i), irq_pulse, tbl[i].pulse);
        end

        // Compare at mtime=10 with PRESCALE 0
        wr(5'h0C, 32'd0);
        wr(5'h08, 32'd10);
        wr(5'h10, 32'h1);
        first_lvl = -1;
        pulses    = 0;
        pulse_at  = -1;
        for (int i = 1; i <= 30; i++) begin
            idle();
            if (irq_pulse) begin pulses++; pulse_at = i; end
            if (irq_level && first_lvl < 0) first_lvl = i;
        end
        check("irq_level_first_cycle", first_lvl, 11);
        check("irq_pulse_count", pulses, 1);
        check("irq_pulse_cycle", pulse_at, 11);
        check("irq_level_held", irq_level, 1'b1);
        wr(5'h08, 32'h100);
        check("irq_level_write_edge", irq_level, 1'b1);
        idle();
        check("irq_level_cleared", irq_level, 1'b0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            idle();
            if (irq_pulse) pulses++;
        end
        check("irq_no_repulse", pulses, 0);

        // PRESCALE 3: ten ticks in forty cycles, then hold with EN=0
        do_reset();
        wr(5'h10, 32'h0301);
        for (int i = 0; i < 40; i++) idle();
        rd(5'h00);
        check("prescale3_mtime", bus_rdata, 32'd10);
        wr(5'h10, 32'h0300);
        for (int i = 0; i < 20; i++) idle();
        rd(5'h00);
        check("disabled_hold", bus_rdata, 32'd10);

        // LO wrap with atomic HI shadow
        do_reset();
        wr(5'h00, 32'hFFFF_FFFE);
        wr(5'h04, 32'd0);
        wr(5'h10, 32'h1);
        idle();
        rd(5'h00);
        check("wrap_lo_read", bus_rdata, 32'hFFFF_FFFF);
        rd(5'h04);
        check("wrap_hi_shadow", bus_rdata, 32'd0);
        rd(5'h04);
        check("wrap_hi_live", bus_rdata, 32'd1);

        // LO write on a carrying tick edge: no carry into HI
        do_reset();
        wr(5'h00, 32'hFFFF_FFFD);
        wr(5'h04, 32'd0);
        wr(5'h10, 32'h1);
        idle();
        idle();
        wr(5'h00, 32'h55);
        rd(5'h00);
        check("lo_write_value", bus_rdata, 32'h55);
        rd(5'h04);
        check("lo_write_hi_shadow", bus_rdata, 32'd0);
        rd(5'h04);
        check("lo_write_hi_live", bus_rdata, 32'd0);

        // Reset with interrupt active and a read in flight
        do_reset();
        wr(5'h0C, 32'd0);
        wr(5'h08, 32'd0);
        idle();
        check("pre_rst_level", irq_level, 1'b1);
        step(1'b0, 1'b1, 1'b0, 5'h08, 32'd0);
        check("mid_rst_ack",   bus_ack,   1'b0);
        check("mid_rst_rdata", bus_rdata, 32'd0);
        check("mid_rst_level", irq_level, 1'b0);
        check("mid_rst_pulse", irq_pulse, 1'b0);
        rd(5'h08);
        check("mid_rst_cmp_lo", bus_rdata, 32'hFFFF_FFFF);
        rd(5'h10);
        check("mid_rst_ctrl", bus_rdata, 32'd0);
        rd(5'h00);
        check("mid_rst_mtime_lo", bus_rdata, 32'd0);
        rd(5'h0C);
        check("mid_rst_cmp_hi", bus_rdata, 32'hFFFF_FFFF);

        // Random traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r_rst  = ($urandom_range(0, 299) != 0);
            r_req  = ($urandom_range(0, 3) != 0);
            r_we   = 1'($urandom_range(0, 1));
            r_addr = 5'($urandom);
            r_wd   = $urandom;
            case (r_addr[4:2])
                3'd1, 3'd3: r_wd = $urandom_range(0, 1);
                3'd2:       if ($urandom_range(0, 1) == 1) r_wd = $urandom_range(0, 64);
                3'd0:       if ($urandom_range(0, 1) == 1) r_wd = $urandom_range(0, 64);
                3'd4:       r_wd[15:8] = 8'($urandom_range(0, 3));
                default: ;
            endcase
            step(r_rst, r_req, r_we, r_addr, r_wd);
            check_model($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
